regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x64 integer register file and shares it between two writeback requesters: ALU (port A) and LSU/MUL (port B).
- Round-robin arbitration over valid/ready handshakes, one registered write stage, and a pending-write scoreboard that issue logic uses to stall on RAW/WAW hazards.
- Sits between execute/memory writeback and the register file's write_en/write_addr/write_data inputs.

Parameters:
XLEN, 64, data width of a register
NREGS, 32, number of architectural registers
AW, 5, register address width (log2 NREGS)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
a_valid_i  input  1  ALU writeback request
a_rd_i  input  AW  ALU destination register
a_data_i  input  XLEN  ALU result
a_ready_o  output  1  ALU request accepted this cycle
b_valid_i  input  1  LSU/MUL writeback request
b_rd_i  input  AW  LSU/MUL destination register
b_data_i  input  XLEN  LSU/MUL result
b_ready_o  output  1  LSU/MUL request accepted this cycle
issue_valid_i  input  1  instruction with a destination is issuing
issue_rd_i  input  AW  destination of issuing instruction
flush_i  input  1  pipeline flush, clears scoreboard
write_en_o  output  1  register file write enable
write_addr_o  output  AW  register file write address
write_data_o  output  XLEN  register file write data
busy_o  output  NREGS  bit n set = write to xn pending

Behaviour:
- Reset (async, rst_i=1): write_en_o=0, write_addr_o=0, write_data_o=0, busy_o=0, round-robin pointer=A. a_ready_o/b_ready_o are 0 while rst_i=1.
- Handshake: a transfer occurs when valid_i && ready_o in the same cycle. ready_o is combinational from the valids and the pointer. At most one ready is high per cycle. Requesters hold valid/rd/data stable until accepted.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port named by the pointer is granted.
  - After any grant, the pointer moves to the other port. Under continuous contention grants strictly alternate A,B,A,B.
- Write stage: the granted request is registered. write_en_o=1 with its rd/data in the cycle after the handshake (latency 1). write_en_o is a single-cycle pulse per transfer. Back-to-back transfers give write_en_o on consecutive cycles.
- x0 writes: a request with rd=0 is accepted normally but produces write_en_o=0; write_addr_o/write_data_o may update.
- Scoreboard:
  - Set: issue_valid_i && issue_rd_i!=0 sets busy[issue_rd_i].
  - Clear: a cycle with write_en_o=1 clears busy[write_addr_o].
  - Set and clear of the same bit in the same cycle: the set wins.
  - busy[0] is always 0.
  - Issue to an already-busy register leaves the bit set. Stalling on it is the issue logic's responsibility.
- Flush: flush_i=1 clears all busy bits next edge, overriding sets and clears in that cycle. An in-flight write stage still commits (write_en_o not suppressed). Arbitration is unaffected.
- Reset mid-operation: the pending write stage is discarded and write_en_o drops immediately. No partial write.

Optional Feature:
REGFILE_WB_BYPASS_EN
- Defined: adds outputs byp_valid_o (1), byp_addr_o (AW), byp_data_o (XLEN). These present the handshake-cycle request (granted rd/data, combinational) so issue can forward a value one cycle before it reaches the register file. byp_valid_o=0 for rd=0 or when no transfer occurs.
- Undefined: these ports do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_i mid-cycle with a_valid_i=1 -> write_en_o, busy_o and both readys are 0 immediately. After release, the first grant goes to A.
- Single requester: a_valid_i=1, a_rd_i=5, a_data_i=64'hDEAD_BEEF_0000_0001 -> a_ready_o=1 in cycle T. In T+1: write_en_o=1, write_addr_o=5, write_data_o=64'hDEAD_BEEF_0000_0001.
- Contention: A (rd=3) and B (rd=7) held valid with 3 requests each -> grants A,B,A,B,A,B. write_addr_o sequence 3,7,3,7,3,7 with no idle cycles.
- x0 drop: b_valid_i=1, b_rd_i=0 -> b_ready_o=1 and write_en_o stays 0 the next cycle.
- Scoreboard: issue rd=9 -> busy_o[9]=1 next cycle. A writes rd=9 while issue_rd_i=9 is asserted in the same commit cycle -> busy_o[9] stays 1. A second write to rd=9 with no issue -> busy_o[9]=0.
- Flush: busy_o=32'h0000_0300 with a write to rd=8 in flight, flush_i=1 -> busy_o=0 next cycle and write_en_o=1 with write_addr_o=8 still occurs.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Writeback bus between the two requesters (ALU = port A, LSU/MUL = port B),
// the issue stage, and the register-file write port.
//   master : requester/issue side (drives valids, rd, data, issue, flush)
//   slave  : arbiter side (drives readys, write port, busy vector)
// Optional macro REGFILE_WB_BYPASS_EN adds byp_valid_o/byp_addr_o/byp_data_o.
interface regfile_wb_if #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = 5
);
   logic             a_valid_i;
   logic [AW-1:0]    a_rd_i;
   logic [XLEN-1:0]  a_data_i;
   logic             a_ready_o;
   logic             b_valid_i;
   logic [AW-1:0]    b_rd_i;
   logic [XLEN-1:0]  b_data_i;
   logic             b_ready_o;
   logic             issue_valid_i;
   logic [AW-1:0]    issue_rd_i;
   logic             flush_i;
   logic             write_en_o;
   logic [AW-1:0]    write_addr_o;
   logic [XLEN-1:0]  write_data_o;
   logic [NREGS-1:0] busy_o;
`ifdef REGFILE_WB_BYPASS_EN
   logic             byp_valid_o;
   logic [AW-1:0]    byp_addr_o;
   logic [XLEN-1:0]  byp_data_o;
`endif

   modport master (
      output a_valid_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
             issue_valid_i, issue_rd_i, flush_i,
      input  a_ready_o, b_ready_o, write_en_o, write_addr_o, write_data_o, busy_o
`ifdef REGFILE_WB_BYPASS_EN
      , input byp_valid_o, byp_addr_o, byp_data_o
`endif
   );

   modport slave (
      input  a_valid_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
             issue_valid_i, issue_rd_i, flush_i,
      output a_ready_o, b_ready_o, write_en_o, write_addr_o, write_data_o, busy_o
`ifdef REGFILE_WB_BYPASS_EN
      , output byp_valid_o, byp_addr_o, byp_data_o
`endif
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between the
// ALU (port A) and LSU/MUL (port B) with round-robin arbitration, registers the
// winning request for one cycle, and keeps a pending-write scoreboard (busy_o).
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : regfile_wb_if.slave (requests, readys, issue/flush, write port, busy)
// Optional macro REGFILE_WB_BYPASS_EN: drives the bypass outputs of the bus with
// the handshake-cycle request so issue can forward one cycle early.
//
// Round-robin pointer:
//   state | meaning
//   PTR_A | port A wins when both ports request
//   PTR_B | port B wins when both ports request
module regfile_wb_arbiter #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input logic         clk_i,
   input logic         rst_i,
   regfile_wb_if.slave bus
);
   typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

   ptr_e             ptr_q, ptr_d;
   logic             wen_q, wen_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [XLEN-1:0]  data_q, data_d;
   logic [NREGS-1:0] busy_q, busy_d;

   logic             grant_a, grant_b, xfer;
   logic [AW-1:0]    g_rd;
   logic [XLEN-1:0]  g_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q  <= PTR_A;
         wen_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         wen_q  <= wen_d;
         addr_q <= addr_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   // Readys are held low during reset so no handshake can complete while the
   // write stage is being cleared.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst_i) begin
         if (bus.a_valid_i && (!bus.b_valid_i || ptr_q == PTR_A)) begin
            grant_a = 1'b1;
         end else if (bus.b_valid_i) begin
            grant_b = 1'b1;
         end
      end
      xfer   = grant_a | grant_b;
      g_rd   = grant_b ? bus.b_rd_i   : bus.a_rd_i;
      g_data = grant_b ? bus.b_data_i : bus.a_data_i;
   end

   always_comb begin
      ptr_d  = ptr_q;
      wen_d  = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (xfer) begin
         ptr_d  = grant_a ? PTR_B : PTR_A;
         // x0 requests are consumed but never reach the register file.
         wen_d  = (g_rd != '0);
         addr_d = g_rd;
         data_d = g_data;
      end
   end

   // Clear first, then set, so an issue landing on the committing register
   // keeps it busy; flush overrides both.
   always_comb begin
      busy_d = busy_q;
      if (wen_q) begin
         busy_d[addr_q] = 1'b0;
      end
      if (bus.issue_valid_i && bus.issue_rd_i != '0) begin
         busy_d[bus.issue_rd_i] = 1'b1;
      end
      if (bus.flush_i) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   assign bus.a_ready_o    = grant_a;
   assign bus.b_ready_o    = grant_b;
   assign bus.write_en_o   = wen_q;
   assign bus.write_addr_o = addr_q;
   assign bus.write_data_o = data_q;
   assign bus.busy_o       = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
   assign bus.byp_valid_o = xfer && (g_rd != '0);
   assign bus.byp_addr_o  = g_rd;
   assign bus.byp_data_o  = g_data;
`endif
endmodule
